sd_kin_sequencer: RTL and testbench

Frequency-hop sequencer for the two-piece sigma-delta sine generator. Holds a small table of tuning words (`kin`) and dwell times and steps through them on command. On each hop it drives a new `kin` into the generator and holds the generator in reset for a fixed settle window, so every tone starts from a clean state. Sits between the control/register interface and the generator's `kin` / `reset` inputs.

---
 rtl/sd_kin_sequencer.sv | 97 +++++++++
 tb/tb_sd_kin_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_kin_sequencer.sv
// sd_kin_sequencer: hops the sigma-delta generator through a table of tuning words, resetting it for a settle window before each dwell
module sd_kin_sequencer #(
  parameter int BITWIDTH = 40,
  parameter int DEPTH = 8,
  parameter int DWELL_W = 24,
  parameter int RST_CYCLES = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(RST_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BITWIDTH-1:0] wr_kval,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [AW-1:0] last_idx,
  input  logic loop,
  input  logic start,
  input  logic abort,
  output logic [BITWIDTH-1:0] kin,
  output logic sd_reset,
  output logic busy,
  output logic done,
  output logic [AW-1:0] step_idx
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DWELL = 2'd3;
  logic [1:0] state;
  logic [BITWIDTH-1:0] kval_mem [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];
  logic [DWELL_W-1:0] dwell_rd;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [SW-1:0] settle_cnt;
  logic [AW-1:0] last_q;
  logic loop_q;
  always_ff @(posedge clk)
    if (wr_en) begin
      kval_mem[wr_addr] <= wr_kval;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  assign dwell_rd = dwell_mem[step_idx];
  assign sd_reset = state != DWELL;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      kin <= '0;
      step_idx <= '0;
      done <= 1'b0;
      last_q <= '0;
      loop_q <= 1'b0;
      settle_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort)
        state <= IDLE;
      else
        case (state)
          IDLE:
            if (start) begin
              state <= LOAD;
              step_idx <= '0;
              last_q <= last_idx;
              loop_q <= loop;
            end
          LOAD: begin
            kin <= kval_mem[step_idx];
            dwell_cnt <= dwell_rd == '0 ? DWELL_W'(1) : dwell_rd;
            settle_cnt <= SW'(RST_CYCLES);
            state <= SETTLE;
          end
          SETTLE: begin
            settle_cnt <= settle_cnt - SW'(1);
            if (settle_cnt == SW'(1))
              state <= DWELL;
          end
          default: begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
            if (dwell_cnt == DWELL_W'(1)) begin
              if (step_idx != last_q) begin
                step_idx <= step_idx + AW'(1);
                state <= LOAD;
              end else if (loop_q) begin
                step_idx <= '0;
                state <= LOAD;
              end else begin
                state <= IDLE;
                done <= 1'b1;
              end
            end
          end
        endcase
    end
endmodule

// File: tb/tb_sd_kin_sequencer.sv
// tb_sd_kin_sequencer: directed checks of hop timing, looping, abort, collisions and reset
module tb_sd_kin_sequencer;
  logic clk = 0;
  logic reset = 1;
  logic wr_en = 0;
  logic [2:0] wr_addr = 0;
  logic [39:0] wr_kval = 0;
  logic [23:0] wr_dwell = 0;
  logic [2:0] last_idx = 0;
  logic loop = 0;
  logic start = 0;
  logic abort = 0;
  logic [39:0] kin;
  logic sd_reset, busy, done;
  logic [2:0] step_idx;
  int tests = 0;
  int fails = 0;

  sd_kin_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_kval(wr_kval),
    .wr_dwell(wr_dwell), .last_idx(last_idx), .loop(loop), .start(start), .abort(abort),
    .kin(kin), .sd_reset(sd_reset), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [39:0] k, input logic [23:0] d);
    wr_en = 1; wr_addr = a; wr_kval = k; wr_dwell = d;
    tick;
    wr_en = 0;
  endtask

  task automatic go(input logic [2:0] last, input logic lp);
    last_idx = last; loop = lp; start = 1;
    tick;
    start = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    tick; tick;
    tests++;
    if ({kin, sd_reset, busy, done, step_idx} !== {40'h0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset: kin=%h sr=%b busy=%b done=%b idx=%0d required kin=0 sr=1 busy=0 done=0 idx=0",
               kin, sd_reset, busy, done, step_idx);
    end
    reset = 0;
    tick;
  endtask

  task automatic test_single;
    wr(0, 40'h000e2ce2c0, 24'd10);
    go(0, 0);
    for (int c = 1; c <= 17; c++) begin
      logic esr, ebusy, edone;
      esr = c <= 5 || c >= 16;
      ebusy = c <= 15;
      edone = c == 16;
      tests++;
      if ({sd_reset, busy, done} !== {esr, ebusy, edone}) begin
        fails++;
        $display("FAIL single c=%0d: sr/busy/done=%b%b%b required %b%b%b", c, sd_reset, busy, done, esr, ebusy, edone);
      end
      if (c >= 2) begin
        tests++;
        if (kin !== 40'h000e2ce2c0) begin
          fails++;
          $display("FAIL single kin c=%0d: got %h required 000e2ce2c0", c, kin);
        end
      end
      tick;
    end
  endtask

  task automatic test_three_step;
    int ndone = 0;
    wr(0, 40'd1, 24'd3);
    wr(1, 40'd2, 24'd0);
    wr(2, 40'd3, 24'd5);
    go(2, 0);
    for (int c = 1; c <= 26; c++) begin
      logic [2:0] eidx;
      logic [39:0] ekin;
      logic esr, ebusy;
      eidx = c <= 8 ? 3'd0 : c <= 14 ? 3'd1 : 3'd2;
      ekin = c <= 9 ? 40'd1 : c <= 15 ? 40'd2 : 40'd3;
      esr = !((c >= 6 && c <= 8) || c == 14 || (c >= 20 && c <= 24));
      ebusy = c <= 24;
      ndone += done ? 1 : 0;
      tests++;
      if (step_idx !== eidx || sd_reset !== esr || busy !== ebusy || done !== (c == 25)) begin
        fails++;
        $display("FAIL three c=%0d: idx=%0d sr=%b busy=%b done=%b required idx=%0d sr=%b busy=%b done=%b",
                 c, step_idx, sd_reset, busy, done, eidx, esr, ebusy, c == 25);
      end
      if (c >= 2) begin
        tests++;
        if (kin !== ekin) begin
          fails++;
          $display("FAIL three kin c=%0d: got %0d required %0d", c, kin, ekin);
        end
      end
      tick;
    end
    tests++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL three done count: got %0d required 1", ndone);
    end
  endtask

  task automatic test_loop_abort;
    wr(0, 40'h10, 24'd2);
    wr(1, 40'h11, 24'd2);
    go(1, 1);
    for (int c = 1; c <= 20; c++) begin
      logic [2:0] eidx;
      eidx = 3'(((c - 1) / 7) % 2);
      tests++;
      if (step_idx !== eidx || busy !== 1'b1) begin
        fails++;
        $display("FAIL loop c=%0d: idx=%0d busy=%b required idx=%0d busy=1", c, step_idx, busy, eidx);
      end
      if (c < 20) tick;
    end
    abort = 1;
    tick;
    abort = 0;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({busy, sd_reset, done, step_idx, kin} !== {1'b0, 1'b1, 1'b0, 3'd0, 40'h10}) begin
        fails++;
        $display("FAIL abort c=%0d: busy=%b sr=%b done=%b idx=%0d kin=%h required 0 1 0 0 10",
                 c, busy, sd_reset, done, step_idx, kin);
      end
      tick;
    end
  endtask

  task automatic test_start_busy;
    wr(0, 40'h20, 24'd3);
    go(0, 0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) begin
        last_idx = 1; loop = 1; start = 1;
      end
      if (c == 5) start = 0;
      tests++;
      if (busy !== (c <= 8) || done !== (c == 9) || step_idx !== 3'd0) begin
        fails++;
        $display("FAIL start_busy c=%0d: busy=%b done=%b idx=%0d required busy=%b done=%b idx=0",
                 c, busy, done, step_idx, c <= 8, c == 9);
      end
      tick;
    end
  endtask

  task automatic test_start_abort;
    start = 1; abort = 1;
    tick;
    tick;
    start = 0; abort = 0;
    tests++;
    if (busy !== 1'b0 || sd_reset !== 1'b1) begin
      fails++;
      $display("FAIL start_abort: busy=%b sr=%b required busy=0 sr=1", busy, sd_reset);
    end
    tick;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_abort later: busy=%b required 0", busy);
    end
  endtask

  task automatic test_write_collision;
    wr(0, 40'h30, 24'd1);
    wr(1, 40'h31, 24'd1);
    go(1, 1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 7) begin
        tests++;
        if (step_idx !== 3'd1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL collision load idx: got %0d required 1", step_idx);
        end
        wr_en = 1; wr_addr = 1; wr_kval = 40'h41; wr_dwell = 24'd1;
      end
      if (c == 8) begin
        wr_en = 0;
        tests++;
        if (kin !== 40'h31) begin
          fails++;
          $display("FAIL collision old kin: got %h required 31", kin);
        end
      end
      if (c == 20) begin
        tests++;
        if (kin !== 40'h41) begin
          fails++;
          $display("FAIL collision new kin: got %h required 41", kin);
        end
      end
      tick;
    end
    abort = 1;
    tick;
    abort = 0;
    tick;
  endtask

  task automatic test_mid_reset;
    wr(0, 40'h50, 24'd10);
    go(0, 0);
    for (int c = 1; c < 8; c++) tick;
    tests++;
    if (sd_reset !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset pre: sr=%b required 0", sd_reset);
    end
    reset = 1;
    tick;
    reset = 0;
    tests++;
    if ({kin, sd_reset, busy, done, step_idx} !== {40'h0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL mid_reset: kin=%h sr=%b busy=%b done=%b idx=%0d required 0 1 0 0 0",
               kin, sd_reset, busy, done, step_idx);
    end
    tick;
    go(0, 0);
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) begin
        tests++;
        if (kin !== 40'h50) begin
          fails++;
          $display("FAIL mid_reset rerun kin: got %h required 50", kin);
        end
      end
      if (c == 16) begin
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL mid_reset rerun done: done=%b busy=%b required 1 0", done, busy);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_three_step;
    test_loop_abort;
    test_start_busy;
    test_start_abort;
    test_write_collision;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
